// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - operand/function entry sequencer driving a four-function ALU
// Collects A, B and the function code on successive button presses, then captures the ALU outputs.
module alu_operand_sequencer #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    input  logic [WIDTH-1:0] i_sw,
    input  logic             i_enter,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [1:0]       o_s,
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_cout,
    input  logic             i_ovr,
    output logic [WIDTH-1:0] o_result,
    output logic             o_coutq,
    output logic             o_ovrq,
    output logic             o_valid,
    output logic             o_busy,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        GET_A = 3'd0,
        GET_B = 3'd1,
        GET_S = 3'd2,
        EXEC  = 3'd3,
        CAPT  = 3'd4,
        SHOW  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_press;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [1:0]             r_s;
    logic [WIDTH-1:0]       r_result;
    logic                   r_coutq;
    logic                   r_ovrq;
    logic                   r_valid;

    // Button is active-low; everything idles at 1 so reset release never looks like a press.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_sync <= '1;
            r_hist <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_enter};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_press = r_hist & ~r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_clear) begin
            w_next = GET_A;
        end else begin
            case (r_state)
                GET_A:   if (w_press) w_next = GET_B;
                GET_B:   if (w_press) w_next = GET_S;
                GET_S:   if (w_press) w_next = EXEC;
                EXEC:    w_next = CAPT;
                CAPT:    w_next = SHOW;
                SHOW:    if (w_press) w_next = GET_A;
                default: w_next = GET_A;
            endcase
        end
    end

    // Presses seen in EXEC/CAPT fall through the case and are simply dropped.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= 2'b00;
            r_result <= '0;
            r_coutq  <= 1'b0;
            r_ovrq   <= 1'b0;
            r_valid  <= 1'b0;
        end else if (i_clear) begin
            r_a      <= '0;
            r_b      <= '0;
            r_s      <= 2'b00;
            r_result <= '0;
            r_coutq  <= 1'b0;
            r_ovrq   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= (r_state == CAPT);
            case (r_state)
                GET_A: if (w_press) r_a <= i_sw;
                GET_B: if (w_press) r_b <= i_sw;
                GET_S: if (w_press) r_s <= i_sw[1:0];
                CAPT: begin
                    r_result <= i_r;
                    r_coutq  <= i_cout;
                    r_ovrq   <= i_ovr;
                end
                default: ;
            endcase
        end
    end

    assign o_a      = r_a;
    assign o_b      = r_b;
    assign o_s      = r_s;
    assign o_result = r_result;
    assign o_coutq  = r_coutq;
    assign o_ovrq   = r_ovrq;
    assign o_valid  = r_valid;
    assign o_busy   = (r_state == EXEC) || (r_state == CAPT);
    assign o_state  = r_state;

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end controller that drives the four-function ALU from a single switch bank and one pushbutton. It collects operand A, operand B and the function code in successive button presses, issues them to the ALU, captures the result and status flags one cycle later, and holds them for display. It acts as the initiator: it owns the ALU's A/B/S inputs and reads back R/Cout/OVR.

## Interface
- WIDTH, 4: operand and result width; must match the ALU.
- SYNC_STAGES, 2: flops in the Enter synchroniser; minimum 2.

- Clock  in  1  system clock, rising-edge.
- Resetn  in  1  asynchronous, active-low reset.
- SW  in  WIDTH  switch bank; operand value, with function code on SW[1:0].
- Enter  in  1  raw pushbutton, active-low (0 = pressed); asynchronous to Clock.
- Clear  in  1  synchronous clear, active-high.
- A  out  WIDTH  registered operand A to ALU.
- B  out  WIDTH  registered operand B to ALU.
- S  out  2  registered function code to ALU (00 add, 01 sub, 10 AND, 11 XOR).
- R_in  in  WIDTH  ALU result.
- Cout_in  in  1  ALU carry-out.
- OVR_in  in  1  ALU overflow.
- Result  out  WIDTH  captured result, held until the next capture or clear.
- CoutQ  out  1  captured carry-out.
- OVRQ  out  1  captured overflow.
- Valid  out  1  one-cycle pulse in the cycle after capture.
- Busy  out  1  high in EXEC and CAPT.
- State  out  3  current state encoding, for LEDs.

## Operation
- Press detection:
  - Enter passes through SYNC_STAGES flops and one history flop. All of these reset to 1 (released).
  - A press is a synchronised 1→0 transition and produces a one-cycle internal pulse.
  - Holding the button produces exactly one pulse. Release produces none.
- States and encodings:
  - GET_A=0: on press, A←SW, go to GET_B.
  - GET_B=1: on press, B←SW, go to GET_S.
  - GET_S=2: on press, S←SW[1:0], go to EXEC.
  - EXEC=3: unconditional one-cycle settle; go to CAPT.
  - CAPT=4: Result←R_in, CoutQ←Cout_in, OVRQ←OVR_in; go to SHOW.
  - SHOW=5: hold everything; on press, go to GET_A. A, B and S keep their values until overwritten.
- Presses arriving in EXEC or CAPT are discarded, not queued.
- Encodings 6 and 7 are illegal. If reached, go to GET_A on the next edge.
- Clear, in any state: A, B, S, Result, CoutQ, OVRQ ← 0; state ← GET_A; Valid ← 0. Clear wins over a simultaneous press.
- No arithmetic is done here. Captured values are bit-exact copies of the ALU outputs.

## Timing
- Reset (Resetn=0, asynchronous):
  - A, B, Result = 0; S = 00; CoutQ, OVRQ, Valid, Busy = 0; State = 0.
  - Synchroniser and history flops = 1.
  - No press is detected on reset release while Enter is held high.
- Enter falls before edge k → press pulse is high in the cycle after edge k+SYNC_STAGES-1 → register update at edge k+SYNC_STAGES. With the default, that is 3 edges after the input falls.
- The GET_S press edge sets S and State=EXEC together.
- Next edge: State=CAPT. The edge after that captures the flags and sets State=SHOW.
- Valid is high for exactly the first cycle in SHOW.
- Issue-to-Valid latency: 2 cycles after the GET_S update edge.
- Busy is high only while State is 3 or 4.
- Resetn asserted mid-sequence (including EXEC/CAPT): all outputs return to reset values immediately; no partial capture survives.

## Test plan
- Add, with the real ALU attached:
  - Stimulus: presses with SW=0111, then 0101, then xx00.
  - Response: A=0111, B=0101, S=00; Result=1100, OVRQ=1, CoutQ=0.
  - Valid pulses once, 2 cycles after S loads.
- Subtract:
  - Stimulus: A=0011, B=0101, S=01.
  - Response: Result=1110, CoutQ=0, OVRQ=0; Busy high exactly 2 cycles.
- Logic op:
  - Stimulus: A=1100, B=1010, S=10.
  - Response: Result=1000; CoutQ/OVRQ equal ALU Cout/OVR. Then S=11 on a new sequence gives Result=0110.
- Held button:
  - Stimulus: Enter low for 50 cycles in GET_A.
  - Response: exactly one advance, to GET_B. A press during EXEC is ignored and State still reaches SHOW.
- Clear:
  - Stimulus: Clear pulsed in GET_S, in the same cycle as a press pulse.
  - Response: State=0; A, B, S, Result all 0; no Valid.
- Reset mid-operation:
  - Stimulus: Resetn low during EXEC.
  - Response: outputs at reset values within the same cycle; after release with Enter high, State stays 0 and no spurious press occurs.
